bus_ack_responder: RTL
======================

// Module: bus_ack_responder
// PURPOSE
//  Bus target that answers the single-cycle req / single-cycle ack handshake.
//  Captures each bus_req pulse and its bus_data into a small FIFO.
//  Returns one bus_ack pulse per captured request, in order, after a fixed service delay.
//  Sits directly downstream of the requester; the $uassert_req_ack check observes the pair.
// PARAMETERS
//  DW        32  width of bus_data / ack_data
//  DEPTH     4   FIFO entries, power of 2, >=2
//  CW        3   count width, = log2(DEPTH)+1
//  ACK_DELAY 2   service cycles per request, >=1
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high reset
//  bus_req   in   1       request pulse; every high cycle is one request
//  bus_data  in   DW      request payload, sampled with bus_req
//  bus_ack   out  1       acknowledge pulse, exactly one cycle per request
//  ack_data  out  DW      payload of the request being acked; 0 when bus_ack=0
//  busy      out  1       FIFO non-empty or FSM not IDLE
//  count     out  CW      FIFO occupancy, 0..DEPTH
//  overflow  out  1       sticky; a request was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset high at an edge): FIFO emptied, FSM=IDLE, bus_ack=0, ack_data=0,
//  count=0, busy=0, overflow=0. Any bus_req sampled in the same cycle is ignored.
//  Pending entries are discarded and no ack is ever produced for them.
//  Push: bus_req=1 at an edge and (count<DEPTH or pop at the same edge)
//  -> {bus_data} is written at the tail.
//  Drop: bus_req=1, count==DEPTH and no pop at that edge -> the request is
//  discarded, overflow<=1 (held until reset), and count is unchanged.
//  Pop: occurs at the edge that ends the ACK state.
//  Simultaneous push and pop: count is unchanged, and both take effect.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH; there is no other wrap handling.
//  FSM: the wait counter is cnt[log2(ACK_DELAY)...], and the states are:
//   IDLE: FIFO non-empty -> WAIT, cnt<=ACK_DELAY-1; otherwise stay.
//   WAIT: cnt!=0 -> cnt<=cnt-1; cnt==0 -> ACK, bus_ack<=1, ack_data<=head.
//   ACK : unconditional pop; bus_ack<=0, ack_data<=0;
//         -> WAIT (cnt<=ACK_DELAY-1) if entries remain after the pop
//            (including one pushed at this edge); else -> IDLE.
//  Latency: request sampled at edge E0 with the FSM idle and the FIFO empty
//  -> bus_ack is high for the cycle following edge E0+ACK_DELAY+1.
//  Throughput: back-to-back queued requests produce ack rising edges
//  spaced ACK_DELAY+1 cycles apart.
//  bus_ack is never high for two consecutive cycles.
//  Ordering: acks (and ack_data) follow strict FIFO order of the accepted requests.
//  All outputs are registered; there is no combinational path from bus_req to any output.
//  busy = (count!=0) | (state!=IDLE), registered with the state.
// TESTING
//  1 Single request, ACK_DELAY=2: req+data=32'hfeed at E0 -> ack=1 and
//    ack_data=32'hfeed in cycle after E3, ack=0 after E4, count back to 0.
//  2 Burst of 4 requests on consecutive cycles (DEPTH=4) -> 4 acks, rising
//    3 cycles apart, ack_data in push order, overflow=0.
//  3 Burst of 6 with no pops possible -> 5th and 6th requests dropped
//    (unless a pop coincides), overflow=1 sticky, only accepted data acked.
//  4 Push coinciding with the ACK-state pop while count=DEPTH -> accepted;
//    count stays DEPTH and the FSM goes to WAIT.
//  5 reset asserted during WAIT with 3 entries queued -> next cycle all outputs 0,
//    and no ack appears afterwards without a new request.
//  6 ACK_DELAY=1, DEPTH=2, 20 randomly spaced pulses, no overflow expected
//    -> ack count equals req count and $uassert_req_ack raises no error.

Source files
------------

// File: rtl/bus_ack_responder.sv
// bus_ack_responder: bus target for the single-cycle req / single-cycle ack
// handshake. Requests are queued in a small FIFO and each one is answered by a
// single bus_ack pulse, in arrival order, after ACK_DELAY service cycles.
module bus_ack_responder #(
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int CW        = 3,
  parameter int ACK_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bus_req,
  input  logic [DW-1:0] bus_data,
  output logic          bus_ack,
  output logic [DW-1:0] ack_data,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wait counter only has to hold ACK_DELAY-1.
  localparam int TW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bus_ack_q, bus_ack_d;
  logic [DW-1:0] ack_data_q, ack_data_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic [DW-1:0] mem [DEPTH];
  logic          full;
  logic          push;
  logic          pop;

  // Next-state logic for FIFO bookkeeping and the service FSM.
  always_comb begin
    pop  = (state_q == ACK);
    full = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a request when the head leaves at the same edge.
    push = bus_req && (!full || pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_ack_d  = 1'b0;
    ack_data_d = '0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (bus_req && !push) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WAIT;
          cnt_d   = TW'(ACK_DELAY - 1);
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else begin
          state_d    = ACK;
          bus_ack_d  = 1'b1;
          ack_data_d = mem[rd_ptr_q];
        end
      end
      ACK: begin
        // Anything left after this pop (including a same-edge push) is served next.
        if (count_d != '0) begin
          state_d = WAIT;
          cnt_d   = TW'(ACK_DELAY - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  // State and output registers; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bus_ack_q  <= 1'b0;
      ack_data_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bus_ack_q  <= bus_ack_d;
      ack_data_q <= ack_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_q] <= bus_data;
  end

  assign bus_ack  = bus_ack_q;
  assign ack_data = ack_data_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
